input_debouncer: RTL and testbench

- Per-bit input conditioner sitting directly upstream of the combinational logic driven from ui_in (e.g. the C_AND gate on ui_in[0]/ui_in[1]).
- Synchronises asynchronous pad inputs (buttons/switches) into clk, filters bounce with a per-channel stability counter, and provides clean levels plus one-cycle rise/fall pulses.
- Downstream logic consumes btn_level in place of raw ui_in bits.

---
 rtl/input_debouncer.sv | 81 ++++++++
 tb/tb_input_debouncer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Per-bit pad input conditioner: two-flop synchroniser, stability counter,
// registered debounced level and one-cycle rise/fall pulses per channel.
module input_debouncer #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  // Synchronisers run regardless of ena so no stale sample is seen on resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          level_q;
    logic          level_nxt;
    logic          rise_q;
    logic          rise_nxt;
    logic          fall_q;
    logic          fall_nxt;

    always_comb begin
      cnt_nxt   = cnt;
      level_nxt = level_q;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      if (ena) begin
        if (s2[i] == level_q) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          level_nxt = s2[i];
          rise_nxt  = s2[i];
          fall_nxt  = ~s2[i];
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        cnt     <= cnt_nxt;
        level_q <= level_nxt;
        rise_q  <= rise_nxt;
        fall_q  <= fall_nxt;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_rise[i]  = rise_q;
    assign btn_fall[i]  = fall_q;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed scoreboard bench for input_debouncer (default parameters).
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] raw_in;
  logic [7:0] btn_level;
  logic [7:0] btn_rise;
  logic [7:0] btn_fall;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] level;
    logic [7:0] rise;
    logic [7:0] fall;
    string      tag;
  } exp_t;

  exp_t sb[$];

  input_debouncer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .raw_in    (raw_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expectation for the coming edge, clock once, then pop and compare.
  task automatic tick(input string tag, input logic [7:0] l, input logic [7:0] r,
                      input logic [7:0] f);
    exp_t e;
    e.level = l;
    e.rise  = r;
    e.fall  = f;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_level"}, btn_level, e.level);
    check({e.tag, "_rise"},  btn_rise,  e.rise);
    check({e.tag, "_fall"},  btn_fall,  e.fall);
  endtask

  task automatic idle(input int n, input string tag, input logic [7:0] l);
    for (int k = 0; k < n; k++) tick(tag, l, 8'h00, 8'h00);
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    raw_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", btn_level, 8'h00);
    check("rst_rise",  btn_rise,  8'h00);
    check("rst_fall",  btn_fall,  8'h00);
    rst_n = 1'b1;

    // Release with all inputs already high
    idle(5, "t1_pre", 8'h00);
    tick("t1_edge6", 8'hFF, 8'hFF, 8'h00);
    tick("t1_edge7", 8'hFF, 8'h00, 8'h00);
    raw_in = 8'h00;
    idle(5, "t1_fall_pre", 8'hFF);
    tick("t1_fall", 8'h00, 8'h00, 8'hFF);
    tick("t1_fall_after", 8'h00, 8'h00, 8'h00);

    // Short glitch is filtered
    raw_in = 8'h01;
    idle(3, "t2_glitch", 8'h00);
    raw_in = 8'h00;
    idle(10, "t2_after", 8'h00);

    // Clean press and release on bit 1
    raw_in = 8'h02;
    idle(5, "t3_pre", 8'h00);
    tick("t3_rise", 8'h02, 8'h02, 8'h00);
    idle(4, "t3_hold", 8'h02);
    raw_in = 8'h00;
    idle(5, "t3_rel", 8'h02);
    tick("t3_fall", 8'h00, 8'h00, 8'h02);
    idle(4, "t3_idle", 8'h00);

    // Bouncing bit 2, then settles high
    for (int k = 0; k < 6; k++) begin
      raw_in = (k % 2 == 0) ? 8'h04 : 8'h00;
      idle(2, "t4_bounce", 8'h00);
    end
    raw_in = 8'h04;
    idle(5, "t4_pre", 8'h00);
    tick("t4_rise", 8'h04, 8'h04, 8'h00);
    idle(3, "t4_hold", 8'h04);

    // Async reset mid-count, between clock edges
    raw_in = 8'h08;
    idle(4, "t5_count", 8'h04);
    rst_n = 1'b0;
    #2;
    check("t5_async_level", btn_level, 8'h00);
    check("t5_async_rise",  btn_rise,  8'h00);
    check("t5_async_fall",  btn_fall,  8'h00);
    #1;
    rst_n = 1'b1;
    idle(5, "t5_pre", 8'h00);
    tick("t5_rise", 8'h08, 8'h08, 8'h00);
    idle(2, "t5_hold", 8'h08);

    // Bring bit 7 high, then opposite simultaneous edges with ena paused
    raw_in = 8'h88;
    idle(5, "t6_setup", 8'h08);
    tick("t6_setup_rise", 8'h88, 8'h80, 8'h00);
    idle(2, "t6_setup_hold", 8'h88);
    raw_in = 8'h09;
    idle(4, "t6_count", 8'h88);
    ena = 1'b0;
    idle(2, "t6_paused", 8'h88);
    ena = 1'b1;
    idle(1, "t6_resume", 8'h88);
    tick("t6_update", 8'h09, 8'h01, 8'h80);
    idle(2, "t6_after", 8'h09);

    // ena low exactly on the accepting edge suppresses it by one cycle
    raw_in = 8'h08;
    idle(5, "t7_count", 8'h09);
    ena = 1'b0;
    tick("t7_held", 8'h09, 8'h00, 8'h00);
    ena = 1'b1;
    tick("t7_fall", 8'h08, 8'h00, 8'h01);
    idle(2, "t7_after", 8'h08);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
